// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Purpose : groups the instruction-memory handshake and the decode-side
//           instruction output of the fetch queue into one bundle.
// Signals :
//   imem_req    fetch request to instruction memory
//   imem_addr   fetch address (always the current fetch pc)
//   imem_gnt    memory accepts the request this cycle
//   imem_rvalid response word valid, responses return in request order
//   imem_rdata  response instruction word
//   stall       decode hazard, holds the head entry
//   inst_valid  head entry valid for decode
//   inst        head instruction word
//   inst_pc     address of the head instruction
// Modports: master = fetch queue, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, stall
  );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Purpose : instruction prefetch queue. Issues in-order fetch requests,
//           buffers returned words with their pc in a DEPTH-entry FIFO and
//           presents the head entry to decode. A redirect flushes the FIFO,
//           restarts fetch at the new pc and discards responses that were
//           still in flight.
// Ports   :
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   i_halt         blocks new fetch requests
//   i_redirect     flush and restart fetch at i_redirect_pc
//   i_redirect_pc  new fetch address
//   bus            fetch_queue_if.master (imem handshake + decode output)
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int MAX_PEND = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_halt,
  input  logic          i_redirect,
  input  logic [15:0]   i_redirect_pc,
  fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_resp_pc;
  logic [15:0]   r_q_pc   [DEPTH];
  logic [15:0]   r_q_inst [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_pend;
  logic [PW-1:0] r_drop;

  logic          w_resp;
  logic          w_resp_drop;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic          w_req;
  logic          w_accept;
  logic [SW-1:0] w_inflight;

  // A response is only meaningful while something is outstanding.
  assign w_resp      = bus.imem_rvalid && (r_pend != '0);
  assign w_resp_drop = w_resp && (r_drop != '0);
  assign w_push      = w_resp && (r_drop == '0);

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && !bus.stall;

  // Entries already queued plus responses that will be kept; issuing only
  // while this is below DEPTH guarantees a free slot for every kept word.
  assign w_inflight = SW'(r_count) + SW'(r_pend) - SW'(r_drop);

  assign w_req = !reset && !i_halt && !i_redirect &&
                 (r_pend < PW'(MAX_PEND)) &&
                 (w_inflight < SW'(DEPTH));
  assign w_accept = w_req && bus.imem_gnt;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = r_q_inst[r_head];
  assign bus.inst_pc    = r_q_pc[r_head];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= '0;
      r_resp_pc  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (i_redirect) begin
      // Everything still in flight after this cycle is stale; a response
      // landing in this very cycle is consumed here and simply not queued.
      r_fetch_pc <= i_redirect_pc;
      r_resp_pc  <= i_redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pend     <= r_pend - PW'(w_resp);
      r_drop     <= r_pend - PW'(w_resp);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 16'd2;
      end
      if (w_push) begin
        r_q_pc[r_tail]   <= r_resp_pc;
        r_q_inst[r_tail] <= bus.imem_rdata;
        r_tail           <= r_tail + AW'(1);
        r_resp_pc        <= r_resp_pc + 16'd2;
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_resp_drop) begin
        r_drop <= r_drop - PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_pend  <= r_pend + PW'(w_accept) - PW'(w_resp);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Purpose : self-checking bench for fetch_queue. A memory model answers
//           accepted requests after a programmable latency; a scoreboard
//           queue holds the {pc, word} expected for every accepted fetch
//           and is compared against decode-side pops.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int DEPTH    = 4;
  localparam int MAX_PEND = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } ent_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;

  fetch_queue_if ifc ();

  assign ifc.stall = stall;

  fetch_queue #(.DEPTH(DEPTH), .MAX_PEND(MAX_PEND)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_halt        (halt),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .bus           (ifc)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          lat     = 1;
  int          last_due = 0;
  bit          gnt_rand = 1'b0;
  int          pop_cnt = 0;
  logic [15:0] m_pc    = '0;
  ent_t        exp_q [$];
  mreq_t       mem_q [$];
  logic [15:0] pop_log [$];

  logic        s_req;
  logic [15:0] s_addr;
  logic        s_valid;
  logic [15:0] s_inst;
  logic [15:0] s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [15:0] r;
    r = {a[3:0], a[15:4]} ^ 16'h9E37;
    return r;
  endfunction

  function automatic bit due_now();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  // One clock cycle: drive memory response, sample outputs, update model.
  task automatic tick();
    ent_t  e;
    mreq_t m;
    bit    dv;
    #1;
    dv = due_now();
    ifc.imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    ifc.imem_rvalid = dv;
    if (dv) begin
      m = mem_q.pop_front();
      ifc.imem_rdata = word_of(m.addr);
    end else begin
      ifc.imem_rdata = 16'($urandom);
    end
    #1;
    s_req   = ifc.imem_req;
    s_addr  = ifc.imem_addr;
    s_valid = ifc.inst_valid;
    s_inst  = ifc.inst;
    s_pc    = ifc.inst_pc;
    if (reset) begin
      chk("req_in_reset", s_req, 0);
      exp_q.delete();
      m_pc = '0;
    end else if (redirect) begin
      chk("req_in_redirect", s_req, 0);
      exp_q.delete();
      m_pc = redirect_pc;
    end else begin
      if (halt) chk("req_in_halt", s_req, 0);
      if (s_req && ifc.imem_gnt) begin
        chk("imem_addr", s_addr, m_pc);
        e.pc   = m_pc;
        e.word = word_of(m_pc);
        exp_q.push_back(e);
        m.addr = s_addr;
        m.due  = cyc + lat;
        if (m.due <= last_due) m.due = last_due + 1;
        last_due = m.due;
        mem_q.push_back(m);
        m_pc = m_pc + 16'd2;
      end
      if (s_valid && stall && exp_q.size() > 0)
        chk("stall_hold_pc", s_pc, exp_q[0].pc);
      if (s_valid && !stall) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", s_pc, e.pc);
          chk("inst", s_inst, e.word);
        end
        pop_cnt++;
        pop_log.push_back(s_pc);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    halt  = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    tick();
    chk("drain_empty_valid", s_valid, 0);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 40; i++) begin
      if (pop_log.size() >= n) break;
      tick();
    end
    chk("pop_timeout", 32'(pop_log.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    reset           = 1'b1;
    halt            = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    stall           = 1'b0;
    ifc.imem_gnt    = 1'b0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Reset state and first-fetch latency (accept N, response N+1, valid N+2).
    tick();
    chk("rst_valid", s_valid, 0);
    chk("rst_inst", s_inst, 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_first_req", s_req, 1);
    tick();
    chk("lat_n1_valid", s_valid, 0);
    tick();
    chk("lat_n2_valid", s_valid, 1);
    chk("lat_n2_pc", s_pc, 16'h0000);

    // Steady streaming: one instruction per cycle.
    p0 = pop_cnt;
    repeat (10) tick();
    chk("stream_rate", pop_cnt - p0, 10);

    // Full queue under stall, then release.
    stall = 1'b1;
    repeat (10) tick();
    chk("full_outstanding", 32'(exp_q.size()), DEPTH);
    chk("full_req_low", s_req, 0);
    stall = 1'b0;
    p0 = pop_cnt;
    repeat (12) tick();
    chk("full_resume_rate", pop_cnt - p0, 12);

    // Redirect with two requests outstanding.
    lat = 3;
    for (int i = 0; i < 30; i++) begin
      if (mem_q.size() == 2 && !due_now()) break;
      tick();
    end
    chk("redir_pend2_setup", 32'(mem_q.size()), 2);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    pop_log.delete();
    tick();
    chk("redir_valid_after", s_valid, 0);
    wait_pops(1);
    if (pop_log.size() > 0) chk("redir_first_pc", pop_log[0], 16'h0040);

    // Redirect coinciding with a response and a pop.
    drain();
    halt  = 1'b0;
    lat   = 2;
    stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ifc.inst_valid && due_now() && mem_q.size() == 2) break;
      tick();
    end
    chk("redir_resp_setup", 32'(ifc.inst_valid && due_now() && mem_q.size() == 2), 1);
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    pop_log.delete();
    tick();
    chk("redir_resp_valid_after", s_valid, 0);
    wait_pops(2);
    if (pop_log.size() > 1) begin
      chk("redir_resp_pc0", pop_log[0], 16'h0100);
      chk("redir_resp_pc1", pop_log[1], 16'h0102);
    end

    // Address wrap.
    lat         = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    pop_log.delete();
    wait_pops(3);
    if (pop_log.size() > 2) begin
      chk("wrap_pc0", pop_log[0], 16'hFFFC);
      chk("wrap_pc1", pop_log[1], 16'hFFFE);
      chk("wrap_pc2", pop_log[2], 16'h0000);
    end

    // Reset mid-stream with two outstanding; late responses must be ignored.
    lat = 3;
    for (int i = 0; i < 30; i++) begin
      if (mem_q.size() == 2) break;
      tick();
    end
    chk("rst2_pend2_setup", 32'(mem_q.size()), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    halt  = 1'b1;
    tick();
    chk("rst2_valid", s_valid, 0);
    chk("rst2_inst", s_inst, 0);
    chk("rst2_pc", s_pc, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst2_late_ignored", s_valid, 0);
    end
    halt = 1'b0;
    lat  = 1;
    tick();
    chk("rst2_first_req", s_req, 1);
    chk("rst2_first_addr", s_addr, 16'h0000);
    pop_log.delete();
    wait_pops(2);
    if (pop_log.size() > 1) chk("rst2_pc1", pop_log[1], 16'h0002);

    // Randomised mix of stall, halt, grant, latency and redirect.
    gnt_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 15) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      lat         = $urandom_range(1, 4);
      tick();
    end
    redirect = 1'b0;
    gnt_rand = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
